// File: rtl/conv33_pkg.sv
// Shared definitions for the 3x3 convolution scheduler: FSM state encoding and kernel size.
package conv33_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int KERNEL = 3;

endpackage

// File: rtl/conv33_win_cnt.sv
// Row/column index of the next 3x3 window; raster order over the valid output positions.
module conv33_win_cnt
    import conv33_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last
);

    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - KERNEL);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - KERNEL);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             col_wrap;

    always_comb begin
        col_wrap = (col_q == COL_MAX);
        last     = col_wrap && (row_q == ROW_MAX);
        col_d    = col_q;
        row_d    = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (col_wrap) begin
                col_d = '0;
                // after the final window both indices park at zero
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/conv33_sched.sv
// 3x3 convolution scheduler: weight load, window acceptance with in-flight limit, output retire tracking.
// Optional macro CONV33_SCHED_PERF_EN adds the stall_cycles performance counter output.
module conv33_sched
    import conv33_pkg::*;
#(
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             weight_start,
    input  logic             weight_load_done,
    input  logic             win_valid_in,
    output logic             win_ready_out,
    output logic             calc_en,
    input  logic             out_valid,
    input  logic             out_ready_in,
    output logic [CNT_W-1:0] row_idx,
    output logic [CNT_W-1:0] col_idx,
    output logic             err
`ifdef CONV33_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int TOTAL = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);
    localparam int RET_W = $clog2(TOTAL + 1);
    localparam int INF_W = 4;

    state_t           state_q, state_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             ws_q, ws_d;
    logic             err_q, err_d;
    logic             start_acc, accept, retire, ret_ok, win_last, cnt_clr, final_ret;

    always_comb begin
        start_acc     = (state_q == IDLE) && start;
        win_ready_out = (state_q == RUN) && (inflight_q < INF_W'(MAX_INFLIGHT));
        accept        = win_valid_in && win_ready_out;
        calc_en       = accept;
        retire        = out_valid && out_ready_in;
        // a retire with nothing in flight is an error, not a real output
        ret_ok        = retire && (inflight_q != '0);
        final_ret     = ret_ok && (retired_q == RET_W'(TOTAL - 1));
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        cnt_clr       = (state_q == DONE) || start_acc;

        state_d    = state_q;
        inflight_d = inflight_q;
        retired_d  = retired_q;
        ws_d       = 1'b0;
        err_d      = err_q;

        case ({accept, ret_ok})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        if (ret_ok) retired_d = retired_q + 1'b1;

        if (start_acc) err_d = 1'b0;
        if (retire && (inflight_q == '0)) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    ws_d    = 1'b1;
                end
            end
            LOAD_W: begin
                if (weight_load_done) state_d = RUN;
            end
            RUN: begin
                if (final_ret)              state_d = DONE;
                else if (accept && win_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (final_ret) state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                inflight_d = '0;
                retired_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            retired_q  <= '0;
            ws_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            retired_q  <= retired_d;
            ws_q       <= ws_d;
            err_q      <= err_d;
        end
    end

    assign weight_start = ws_q;
    assign err          = err_q;

    conv33_win_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (cnt_clr),
        .col  (col_idx),
        .row  (row_idx),
        .last (win_last)
    );

`ifdef CONV33_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc)
            stall_d = '0;
        else if ((state_q == RUN) && win_valid_in && !win_ready_out && (stall_q != '1))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv33_sched.sv
// Directed testbench for conv33_sched on a 5x5 map (9 windows), MAX_INFLIGHT=4.
`timescale 1ns/1ps
module tb_conv33_sched;
    import conv33_pkg::*;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int MI = 4;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst, start, weight_load_done, win_valid_in, out_valid, out_ready_in;
    logic          busy, done, weight_start, win_ready_out, calc_en, err;
    logic [CW-1:0] row_idx, col_idx;
`ifdef CONV33_SCHED_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int acc_cnt, ret_cnt, done_cnt, ws_cnt, last_ret_cyc, done_cyc, pend;
    bit p1, auto_out;

    always #5 clk = ~clk;

    conv33_sched #(
        .IMG_W        (W),
        .IMG_H        (H),
        .MAX_INFLIGHT (MI),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .weight_start     (weight_start),
        .weight_load_done (weight_load_done),
        .win_valid_in     (win_valid_in),
        .win_ready_out    (win_ready_out),
        .calc_en          (calc_en),
        .out_valid        (out_valid),
        .out_ready_in     (out_ready_in),
        .row_idx          (row_idx),
        .col_idx          (col_idx),
        .err              (err)
`ifdef CONV33_SCHED_PERF_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    task automatic clear_model();
        acc_cnt = 0; ret_cnt = 0; done_cnt = 0; ws_cnt = 0;
        last_ret_cyc = -10; done_cyc = -20; pend = 0; p1 = 0;
        out_valid = 1'b0;
    endtask

    // One clock cycle: called 1ns after a rising edge, samples mid-cycle, returns 1ns after the next edge.
    // The output stage model presents a result 2 cycles after calc_en.
    task automatic cyc();
        bit s_acc, s_ret;
        #3;
        s_acc = calc_en;
        s_ret = out_valid && out_ready_in;
        if (done) begin done_cnt++; done_cyc = cycle; end
        if (weight_start) ws_cnt++;
        if (s_ret) begin ret_cnt++; last_ret_cyc = cycle; end
        if (s_acc) acc_cnt++;
        @(posedge clk); #1;
        cycle++;
        if (s_ret && pend > 0) pend--;
        if (p1) pend++;
        p1 = s_acc;
        if (auto_out) out_valid = (pend > 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; weight_load_done = 1'b0;
        win_valid_in = 1'b0; out_ready_in = 1'b0; auto_out = 1'b1;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic load_weights();
        cyc();
        weight_load_done = 1'b1; cyc(); weight_load_done = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin cyc(); n++; end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required within 300", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; weight_load_done = 1'b0;
        win_valid_in = 1'b1; out_valid = 1'b0; out_ready_in = 1'b0; auto_out = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, weight_start, win_ready_out, calc_en, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000", {busy, done, weight_start, win_ready_out, calc_en, err});
        end
        checks++;
        if (row_idx !== '0 || col_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx: got row=%0d col=%0d required 0/0", row_idx, col_idx);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.inflight_q !== 4'd0 || dut.retired_q !== '0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d inflight=%0d retired=%0d required 0/0/0",
                     dut.state_q, dut.inflight_q, dut.retired_q);
        end
        win_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_basic();
        do_reset();
        out_ready_in = 1'b1;
        pulse_start();
        checks++;
        if (weight_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ws_latency: got ws=%b busy=%b required 1/1", weight_start, busy);
        end
        cyc();
        checks++;
        if (weight_start !== 1'b0 || win_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_ws_pulse: got ws=%b ready=%b required 0/0", weight_start, win_ready_out);
        end
        weight_load_done = 1'b1; cyc(); weight_load_done = 1'b0;
        checks++;
        if (win_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_wld_ready: got %b required 1", win_ready_out);
        end
        win_valid_in = 1'b1;
        run_to_done("basic");
        win_valid_in = 1'b0;
        checks++;
        if (acc_cnt != 9 || ret_cnt != 9) begin
            errors++;
            $display("FAIL basic_counts: got calc_en=%0d retires=%0d required 9/9", acc_cnt, ret_cnt);
        end
        checks++;
        if (done_cyc != last_ret_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d cycles after last retire required 1", done_cyc - last_ret_cyc);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || row_idx !== '0 || col_idx !== '0 || ws_cnt != 1) begin
            errors++;
            $display("FAIL basic_end: got busy=%b err=%b row=%0d col=%0d ws=%0d required 0/0/0/0/1",
                     busy, err, row_idx, col_idx, ws_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready_in = 1'b0;
        pulse_start();
        load_weights();
        win_valid_in = 1'b1;
        repeat (10) cyc();
        checks++;
        if (acc_cnt != 4 || win_ready_out !== 1'b0 || dut.inflight_q !== 4'd4) begin
            errors++;
            $display("FAIL bp_stall: got accepts=%0d ready=%b inflight=%0d required 4/0/4",
                     acc_cnt, win_ready_out, dut.inflight_q);
        end
        checks++;
        if (row_idx !== 10'd1 || col_idx !== 10'd1) begin
            errors++;
            $display("FAIL bp_idx: got row=%0d col=%0d required 1/1", row_idx, col_idx);
        end
        out_ready_in = 1'b1;
        run_to_done("bp");
        win_valid_in = 1'b0;
        checks++;
        if (acc_cnt != 9 || ret_cnt != 9 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_complete: got accepts=%0d retires=%0d done=%0d required 9/9/1", acc_cnt, ret_cnt, done_cnt);
        end
    endtask

    task automatic test_start_ignore();
        do_reset();
        out_ready_in = 1'b1;
        pulse_start();
        cyc();
        pulse_start();
        checks++;
        if (weight_start !== 1'b0 || dut.state_q !== LOAD_W) begin
            errors++;
            $display("FAIL ign_loadw: got ws=%b state=%0d required 0/1", weight_start, dut.state_q);
        end
        weight_load_done = 1'b1; cyc(); weight_load_done = 1'b0;
        win_valid_in = 1'b1; repeat (3) cyc(); win_valid_in = 1'b0;
        cyc();
        pulse_start();
        checks++;
        if (acc_cnt != 3 || row_idx !== 10'd1 || col_idx !== 10'd0 || weight_start !== 1'b0) begin
            errors++;
            $display("FAIL ign_run: got accepts=%0d row=%0d col=%0d ws=%b required 3/1/0/0",
                     acc_cnt, row_idx, col_idx, weight_start);
        end
        win_valid_in = 1'b1;
        run_to_done("ign");
        win_valid_in = 1'b0;
        repeat (5) cyc();
        checks++;
        if (ws_cnt != 1 || done_cnt != 1 || acc_cnt != 9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_end: got ws=%0d done=%0d accepts=%0d busy=%b required 1/1/9/0",
                     ws_cnt, done_cnt, acc_cnt, busy);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        auto_out = 1'b0;
        out_ready_in = 1'b1;
        pulse_start();
        load_weights();
        win_valid_in = 1'b1;
        repeat (6) cyc();
        checks++;
        if (acc_cnt != 4 || dut.inflight_q !== 4'd4 || win_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL same_full: got accepts=%0d inflight=%0d ready=%b required 4/4/0",
                     acc_cnt, dut.inflight_q, win_ready_out);
        end
        out_valid = 1'b1;
        #1;
        checks++;
        if (win_ready_out !== 1'b0 || calc_en !== 1'b0) begin
            errors++;
            $display("FAIL same_at4: got ready=%b calc_en=%b required 0/0", win_ready_out, calc_en);
        end
        cyc();
        out_valid = 1'b0;
        checks++;
        if (dut.inflight_q !== 4'd3 || win_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL same_ret: got inflight=%0d ready=%b required 3/1", dut.inflight_q, win_ready_out);
        end
        out_valid = 1'b1;
        cyc();
        out_valid = 1'b0;
        checks++;
        if (dut.inflight_q !== 4'd3 || acc_cnt != 5 || ret_cnt != 2) begin
            errors++;
            $display("FAIL same_at3: got inflight=%0d accepts=%0d retires=%0d required 3/5/2",
                     dut.inflight_q, acc_cnt, ret_cnt);
        end
        win_valid_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        out_ready_in = 1'b1;
        pulse_start();
        load_weights();
        win_valid_in = 1'b1;
        while (acc_cnt < 5 && n < 50) begin cyc(); n++; end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, weight_start, win_ready_out, calc_en, err} !== 6'b0 || row_idx !== '0 || col_idx !== '0) begin
            errors++;
            $display("FAIL mid_outputs: got flags=%b row=%0d col=%0d required 0", 
                     {busy, done, weight_start, win_ready_out, calc_en, err}, row_idx, col_idx);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.inflight_q !== 4'd0 || dut.retired_q !== '0) begin
            errors++;
            $display("FAIL mid_state: got state=%0d inflight=%0d retired=%0d required 0/0/0",
                     dut.state_q, dut.inflight_q, dut.retired_q);
        end
        win_valid_in = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) cyc();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone: got done=%0d busy=%b required 0/0", done_cnt, busy);
        end
        pulse_start();
        load_weights();
        win_valid_in = 1'b1;
        run_to_done("mid");
        win_valid_in = 1'b0;
        checks++;
        if (acc_cnt != 9 || ret_cnt != 9 || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_rerun: got accepts=%0d retires=%0d done=%0d required 9/9/1", acc_cnt, ret_cnt, done_cnt);
        end
    endtask

    task automatic test_err();
        do_reset();
        auto_out = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_init: got %b required 0", err);
        end
        out_valid = 1'b1; out_ready_in = 1'b1;
        cyc();
        out_valid = 1'b0;
        repeat (3) cyc();
        checks++;
        if (err !== 1'b1 || dut.inflight_q !== 4'd0) begin
            errors++;
            $display("FAIL err_sticky: got err=%b inflight=%0d required 1/0", err, dut.inflight_q);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b required 0", err);
        end
    endtask

`ifdef CONV33_SCHED_PERF_EN
    task automatic test_perf();
        int n = 0;
        do_reset();
        out_ready_in = 1'b0;
        pulse_start();
        load_weights();
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_init: got %0d required 0", stall_cycles);
        end
        win_valid_in = 1'b1;
        while (acc_cnt < 4 && n < 20) begin cyc(); n++; end
        repeat (7) cyc();
        win_valid_in = 1'b0;
        cyc();
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++;
            $display("FAIL perf_stall: got %0d required 7", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignore();
        test_same_cycle();
        test_reset_mid();
        test_err();
`ifdef CONV33_SCHED_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
